// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer
// Collects up to NRET retirements per cycle from parallel RVFI lanes,
// compacts them in lane order into a circular FIFO and emits one retirement
// per cycle. It also flags dropped lanes (overflow) and gaps in rvfi_order.
module rvfi_retire_serializer #(
    parameter int NRET    = 2,
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 64,
    localparam int LW     = $clog2(DEPTH + 1),
    localparam int PW     = $clog2(DEPTH),
    localparam int EW     = ORDER_W + 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NRET-1:0]         in_valid,
    input  logic [NRET*ORDER_W-1:0] in_order,
    input  logic [NRET-1:0]         in_trap,
    input  logic [NRET-1:0]         in_intr,
    output logic                    out_valid,
    output logic [ORDER_W-1:0]      out_order,
    output logic                    out_trap,
    output logic                    out_intr,
    output logic [LW-1:0]           level,
    output logic                    overflow,
    output logic                    order_err
);

    // Entry layout: {order, trap, intr}
    logic [EW-1:0]      mem_q [DEPTH];

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               out_valid_q, out_valid_d;
    logic [ORDER_W-1:0] out_order_q, out_order_d;
    logic               out_trap_q, out_trap_d;
    logic               out_intr_q, out_intr_d;
    logic               overflow_q, overflow_d;
    logic               order_err_q, order_err_d;
    logic [ORDER_W-1:0] exp_order_q, exp_order_d;

    // Pop whenever anything is buffered; free space counts the slot the pop vacates.
    logic               pop;
    logic [LW:0]        free_slots;
    logic [LW:0]        lane_off [NRET];
    logic [NRET-1:0]    lane_acc;
    logic [LW:0]        acc_cnt;
    logic [PW-1:0]      lane_addr [NRET];
    logic [EW-1:0]      lane_entry [NRET];
    logic [EW-1:0]      head;
    logic [ORDER_W-1:0] head_order;

    assign pop        = (level_q != '0);
    assign free_slots = (LW+1)'(DEPTH) - {1'b0, level_q} + (LW+1)'(pop);
    assign head       = mem_q[rd_ptr_q];
    assign head_order = head[EW-1:2];

    // Lane offsets: valid lanes take consecutive slots; only a prefix that fits is accepted.
    always_comb begin
        logic [LW:0] run;
        run      = '0;
        acc_cnt  = '0;
        lane_acc = '0;
        for (int i = 0; i < NRET; i++) begin
            lane_off[i] = run;
            if (in_valid[i]) begin
                lane_acc[i] = (run < free_slots);
                run         = run + 1'b1;
            end
            if (lane_acc[i]) begin
                acc_cnt = acc_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_lane
            assign lane_addr[gi]  = wr_ptr_q + lane_off[gi][PW-1:0];
            assign lane_entry[gi] = {in_order[gi*ORDER_W +: ORDER_W], in_trap[gi], in_intr[gi]};
        end
    endgenerate

    // Next-state for pointers, occupancy, output register and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + acc_cnt[PW-1:0];
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q + acc_cnt[LW-1:0] - LW'(pop);
        out_valid_d = 1'b0;
        out_order_d = out_order_q;
        out_trap_d  = out_trap_q;
        out_intr_d  = out_intr_q;
        overflow_d  = overflow_q | (|(in_valid & ~lane_acc));
        order_err_d = order_err_q;
        exp_order_d = exp_order_q;
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
            out_order_d = head_order;
            out_trap_d  = head[1];
            out_intr_d  = head[0];
            if (head_order != exp_order_q) begin
                order_err_d = 1'b1;
            end
            // Resync on every pop so one gap raises the flag once, not forever.
            exp_order_d = head_order + 1'b1;
        end
    end

    // Storage writes; no reset needed, and inputs are ignored while in reset.
    always_ff @(posedge clock) begin
        if (resetn) begin
            for (int i = 0; i < NRET; i++) begin
                if (lane_acc[i]) begin
                    mem_q[lane_addr[i]] <= lane_entry[i];
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_order_q <= '0;
            out_trap_q  <= 1'b0;
            out_intr_q  <= 1'b0;
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
            exp_order_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_order_q <= out_order_d;
            out_trap_q  <= out_trap_d;
            out_intr_q  <= out_intr_d;
            overflow_q  <= overflow_d;
            order_err_q <= order_err_d;
            exp_order_q <= exp_order_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_order = out_order_q;
    assign out_trap  = out_trap_q;
    assign out_intr  = out_intr_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign order_err = order_err_q;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Scoreboard bench for rvfi_retire_serializer: the driver queues expected
// retirements, a monitor pops and compares on every out_valid cycle.
module tb_rvfi_retire_serializer;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;
    localparam int OW    = 64;
    localparam int LW    = $clog2(DEPTH + 1);

    logic                 clock = 1'b0;
    logic                 resetn;
    logic [NRET-1:0]      in_valid;
    logic [NRET*OW-1:0]   in_order;
    logic [NRET-1:0]      in_trap;
    logic [NRET-1:0]      in_intr;
    logic                 out_valid;
    logic [OW-1:0]        out_order;
    logic                 out_trap;
    logic                 out_intr;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic                 order_err;

    int checks = 0;
    int errors = 0;
    logic [OW+1:0] sb [$];
    logic [OW+1:0] mon_e;

    always #5 clock = ~clock;

    rvfi_retire_serializer #(.NRET(NRET), .DEPTH(DEPTH), .ORDER_W(OW)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_order  (in_order),
        .in_trap   (in_trap),
        .in_intr   (in_intr),
        .out_valid (out_valid),
        .out_order (out_order),
        .out_trap  (out_trap),
        .out_intr  (out_intr),
        .level     (level),
        .overflow  (overflow),
        .order_err (order_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic [1:0] tr, input logic [1:0] ir);
        in_valid = v;
        in_order = {o1, o0};
        in_trap  = tr;
        in_intr  = ir;
    endtask

    task automatic idle();
        drive(2'b00, 64'd0, 64'd0, 2'b00, 2'b00);
    endtask

    task automatic expect_out(input logic [63:0] o, input logic t, input logic i);
        sb.push_back({o, t, i});
    endtask

    // Reset for two edges with all lanes valid; buffered expectations are discarded.
    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        drive(2'b11, 64'd40, 64'd41, 2'b11, 2'b11);
        sb.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        idle();
    endtask

    // Wait until the FIFO and the output register are both empty, bounded.
    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clock);
            if (level == '0 && !out_valid) done = 1'b1;
        end
        chk({name, "_drain_done"}, 64'(done), 64'd1);
    endtask

    // Monitor: each high out_valid cycle is one new retirement.
    always @(posedge clock) begin
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got order %0d expected no output", out_order);
            end else begin
                mon_e = sb.pop_front();
                chk("out_order", out_order, mon_e[OW+1:2]);
                chk("out_trap", 64'(out_trap), 64'(mon_e[1]));
                chk("out_intr", 64'(out_intr), 64'(mon_e[0]));
                $display("retire order=%0d trap=%0d intr=%0d", out_order, out_trap, out_intr);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        idle();

        // Reset state after two reset cycles with every lane valid
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_order", out_order, 64'd0);
        chk("rst_out_trap", 64'(out_trap), 64'd0);
        chk("rst_out_intr", 64'(out_intr), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_order_err", 64'(order_err), 64'd0);

        // Dual issue {0,1} then {2,3}; output starts two cycles after the first input
        drive(2'b11, 64'd0, 64'd1, 2'b00, 2'b00);
        expect_out(64'd0, 1'b0, 1'b0);
        expect_out(64'd1, 1'b0, 1'b0);
        @(negedge clock);
        chk("dual_e1_valid", 64'(out_valid), 64'd0);
        chk("dual_e1_level", 64'(level), 64'd2);
        drive(2'b11, 64'd2, 64'd3, 2'b00, 2'b00);
        expect_out(64'd2, 1'b0, 1'b0);
        expect_out(64'd3, 1'b0, 1'b0);
        @(negedge clock);
        idle();
        chk("dual_e2_valid", 64'(out_valid), 64'd1);
        chk("dual_e2_level", 64'(level), 64'd3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("dual_stream_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clock);
        chk("dual_end_valid", 64'(out_valid), 64'd0);
        chk("dual_order_err", 64'(order_err), 64'd0);

        // Lane compaction with trap/intr pass-through
        do_reset();
        drive(2'b10, 64'd99, 64'd0, 2'b11, 2'b00);
        expect_out(64'd0, 1'b1, 1'b0);
        @(negedge clock);
        drive(2'b01, 64'd1, 64'd77, 2'b00, 2'b11);
        expect_out(64'd1, 1'b0, 1'b1);
        @(negedge clock);
        idle();
        drain("compact");
        chk("compact_order_err", 64'(order_err), 64'd0);

        // Overflow: 2 per cycle for 8 cycles; only order 15 is dropped
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 64'(2*c), 64'(2*c+1), 2'b00, 2'b00);
            expect_out(64'(2*c), 1'b0, 1'b0);
            if (c < 7) expect_out(64'(2*c+1), 1'b0, 1'b0);
            @(negedge clock);
            chk("ovf_level", 64'(level), (c + 2 > 8) ? 64'd8 : 64'(c + 2));
            chk("ovf_flag", 64'(overflow), (c == 7) ? 64'd1 : 64'd0);
        end
        idle();
        drain("ovf");
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_order_err", 64'(order_err), 64'd0);

        // Order gap 0,1,5 then 6
        do_reset();
        drive(2'b01, 64'd0, 64'd0, 2'b00, 2'b00);
        expect_out(64'd0, 1'b0, 1'b0);
        @(negedge clock);
        drive(2'b01, 64'd1, 64'd0, 2'b00, 2'b00);
        expect_out(64'd1, 1'b0, 1'b0);
        @(negedge clock);
        idle();
        drain("gap_a");
        chk("gap_before", 64'(order_err), 64'd0);
        drive(2'b01, 64'd5, 64'd0, 2'b00, 2'b00);
        expect_out(64'd5, 1'b0, 1'b0);
        @(negedge clock);
        idle();
        drain("gap_b");
        chk("gap_after5", 64'(order_err), 64'd1);
        drive(2'b01, 64'd6, 64'd0, 2'b00, 2'b00);
        expect_out(64'd6, 1'b0, 1'b0);
        @(negedge clock);
        idle();
        drain("gap_c");
        chk("gap_after6", 64'(order_err), 64'd1);

        // Reset mid-stream at level 5; nothing stale may emerge afterwards
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 64'(2*c), 64'(2*c+1), 2'b00, 2'b00);
            expect_out(64'(2*c), 1'b0, 1'b0);
            expect_out(64'(2*c+1), 1'b0, 1'b0);
            @(negedge clock);
        end
        chk("mid_level5", 64'(level), 64'd5);
        resetn = 1'b0;
        idle();
        sb.delete();
        @(negedge clock);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        chk("mid_idle_level", 64'(level), 64'd0);
        drive(2'b01, 64'd0, 64'd0, 2'b00, 2'b00);
        expect_out(64'd0, 1'b0, 1'b0);
        @(negedge clock);
        idle();
        drain("mid");
        chk("mid_order_err", 64'(order_err), 64'd0);
        chk("mid_overflow", 64'(overflow), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_retire_serializer.md
# rvfi_retire_serializer

Upstream feeder for the per-channel RVFI cover/count checks. Accepts up to NRET retirements per cycle on parallel RVFI lanes, compacts them into a FIFO in lane order, and emits one retirement per cycle on a single serial channel. It also flags FIFO overflow and breaks in the `rvfi_order` sequence, so downstream counters see a strictly ordered, single-lane stream.

## Interface
Parameters:
- `NRET`, 2: number of parallel input lanes, 1..4.
- `DEPTH`, 8: FIFO entries, power of two, at least 2*NRET.
- `ORDER_W`, 64: width of the order field.

Ports:
- `clock`  in  1  single clock; all logic is rising-edge.
- `resetn`  in  1  synchronous, active-low reset.
- `in_valid`  in  NRET  per-lane retirement valid.
- `in_order`  in  NRET*ORDER_W  per-lane `rvfi_order`; lane i occupies bits [i*ORDER_W +: ORDER_W].
- `in_trap`  in  NRET  per-lane trap flag.
- `in_intr`  in  NRET  per-lane intr flag.
- `out_valid`  out  1  serial retirement valid.
- `out_order`  out  ORDER_W  order of the emitted retirement.
- `out_trap`  out  1  trap flag of the emitted retirement.
- `out_intr`  out  1  intr flag of the emitted retirement.
- `level`  out  clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when one or more valid lanes are dropped.
- `order_err`  out  1  sticky; set when an emitted order differs from the expected order.

## Operation
- Entry format: {order, trap, intr}. Storage is a circular buffer with wrapping `wr_ptr`/`rd_ptr` (clog2(DEPTH) bits) and an explicit occupancy `level`.
- Push: each cycle, k = popcount(`in_valid`). Valid lanes are written at consecutive slots from `wr_ptr`, lowest lane index first, skipping invalid lanes. `wr_ptr` advances by the number of entries accepted, modulo DEPTH.
- Pop: when `level` > 0 at a rising edge, the head entry moves into the output register, `out_valid` is set to 1, and `rd_ptr` increments. When `level` == 0, `out_valid` is set to 0 and the `out_*` data fields hold their previous values.
- Simultaneous push and pop: the pop uses pre-edge contents. Free space = DEPTH − `level` + pop, where pop is 1 if `level` > 0.
- Overflow: if k exceeds free space, only the lowest-indexed lanes that fit are accepted and the rest are dropped. `overflow` sets and stays set until reset.
- Level update: `level` = `level` + accepted − pop.
- Order check: internal `exp_order` (ORDER_W bits) resets to 0. On each pop, if the popped order ≠ `exp_order`, `order_err` sets (sticky). In all pop cases `exp_order` is then loaded with popped order + 1, truncated to ORDER_W, so the check resyncs after an error and the all-ones value wraps to 0 without error.
- Trap and intr flags pass through unmodified. Both set on one entry is legal and is not checked here.
- Reset: when `resetn` is 0 at a rising edge, the following are cleared, with inputs ignored that cycle:
  - pointers, `level` = 0;
  - `out_valid` = 0, `out_order` = 0, `out_trap` = 0, `out_intr` = 0;
  - `overflow` = 0, `order_err` = 0, `exp_order` = 0.
  Reset mid-stream discards all buffered entries. Storage array contents need no reset.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: a lane sampled at edge t is written to the FIFO at t. It can be popped at edge t+1 at the earliest, so `out_valid` is high in the cycle after t+1 (2 cycles input-to-output when the FIFO is empty).
- Throughput: one output per cycle. Sustained input above 1 per cycle fills the FIFO at (k−1) entries per cycle.
- `level`, `overflow` and `order_err` reflect the state after the most recent edge. `overflow` asserts in the cycle after the dropping edge.
- There is no backpressure to the core. Lanes that do not fit are dropped and flagged via `overflow`.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with all `in_valid` set → all outputs 0 and `level`=0 after release.
- Dual issue in order: NRET=2, feed {0,1} then {2,3} on consecutive cycles → `out_order` is 0,1,2,3 on 4 consecutive cycles starting 2 cycles after the first input, with `order_err`=0.
- Lane compaction and flags: `in_valid`=2'b10 with order 0 and trap=1, then 2'b01 with order 1 and intr=1 → output order 0 with trap=1, then order 1 with intr=1.
- Overflow: DEPTH=8, feed 2 per cycle for 8 cycles → `level` saturates at 8, the first 8+7=15 orders (0..14) come out in sequence, and `overflow`=1 after the first drop edge.
- Order gap: feed orders 0,1,5 → `order_err` rises after the pop of 5. A subsequent 6 produces no further change and the flag stays 1.
- Reset mid-stream with `level`=5 → `out_valid`=0 the next cycle and no stale entries emerge after release. The first post-reset order 0 passes with no `order_err`.
